// File: rtl/nf10_dst_port_demux.sv
// Multicast output demux: replicates each AXI4-Stream packet to every port in its
// tuser destination bitmap, tracking per-port acceptance, and drops empty-bitmap packets.
module nf10_dst_port_demux #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 8,
    parameter int DST_PORT_POS       = 24
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESET,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,

    output logic [C_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                              M_AXIS_TLAST,
    output logic [NUM_PORTS-1:0]              M_AXIS_TVALID,
    input  logic [NUM_PORTS-1:0]              M_AXIS_TREADY,

    output logic [31:0]                       DROP_COUNT
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t                          state_reg;
    logic [NUM_PORTS-1:0]            mask_reg;
    logic [NUM_PORTS-1:0]            pending_reg;
    logic [NUM_PORTS-1:0]            pending_next;
    logic [NUM_PORTS-1:0]            hdr_mask;
    logic [NUM_PORTS-1:0]            load_mask;
    logic                            reg_free;
    logic                            in_ready;
    logic                            in_accept;
    logic                            load_beat;
    logic                            drop_hdr;

    logic [C_AXIS_DATA_WIDTH-1:0]    data_reg;
    logic [STRB_W-1:0]               strb_reg;
    logic [C_AXIS_TUSER_WIDTH-1:0]   user_reg;
    logic                            last_reg;
    logic [31:0]                     drop_count_reg;

    // The output register is free once every port still owing a handshake takes it this cycle,
    // which lets a new beat load on the same edge without a bubble.
    always_comb begin
        pending_next = pending_reg & ~M_AXIS_TREADY;
        reg_free     = (pending_next == '0);
        in_ready     = (state_reg == ST_DROP) ? 1'b1 : reg_free;
        in_accept    = S_AXIS_TVALID & in_ready;
        hdr_mask     = S_AXIS_TUSER[DST_PORT_POS +: NUM_PORTS];
        load_beat    = 1'b0;
        drop_hdr     = 1'b0;
        load_mask    = mask_reg;
        case (state_reg)
            ST_HEADER: begin
                if (in_accept) begin
                    if (hdr_mask != '0) begin
                        load_beat = 1'b1;
                        load_mask = hdr_mask;
                    end else begin
                        drop_hdr  = 1'b1;
                    end
                end
            end
            ST_FORWARD: begin
                load_beat = in_accept;
            end
            default: begin
                load_beat = 1'b0;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_reg <= ST_HEADER;
            mask_reg  <= '0;
        end else if (in_accept) begin
            case (state_reg)
                ST_HEADER: begin
                    if (hdr_mask != '0) begin
                        mask_reg  <= hdr_mask;
                        state_reg <= S_AXIS_TLAST ? ST_HEADER : ST_FORWARD;
                    end else begin
                        state_reg <= S_AXIS_TLAST ? ST_HEADER : ST_DROP;
                    end
                end
                ST_FORWARD: begin
                    if (S_AXIS_TLAST) begin
                        state_reg <= ST_HEADER;
                    end
                end
                ST_DROP: begin
                    if (S_AXIS_TLAST) begin
                        state_reg <= ST_HEADER;
                    end
                end
                default: begin
                    state_reg <= ST_HEADER;
                end
            endcase
        end
    end

    // Shared beat register; only reloaded when no port still owes a handshake on it.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            data_reg <= '0;
            strb_reg <= '0;
            user_reg <= '0;
            last_reg <= 1'b0;
        end else if (load_beat) begin
            data_reg <= S_AXIS_TDATA;
            strb_reg <= S_AXIS_TSTRB;
            user_reg <= S_AXIS_TUSER;
            last_reg <= S_AXIS_TLAST;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            always_ff @(posedge AXI_ACLK) begin
                if (AXI_RESET) begin
                    pending_reg[gi] <= 1'b0;
                end else if (load_beat) begin
                    pending_reg[gi] <= load_mask[gi];
                end else begin
                    pending_reg[gi] <= pending_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            drop_count_reg <= '0;
        end else if (drop_hdr) begin
            drop_count_reg <= drop_count_reg + 32'd1;
        end
    end

    assign S_AXIS_TREADY = in_ready;
    assign M_AXIS_TDATA  = data_reg;
    assign M_AXIS_TSTRB  = strb_reg;
    assign M_AXIS_TUSER  = user_reg;
    assign M_AXIS_TLAST  = last_reg;
    assign M_AXIS_TVALID = pending_reg;
    assign DROP_COUNT    = drop_count_reg;

endmodule

// File: tb/tb_nf10_dst_port_demux.sv
// Bench for nf10_dst_port_demux: per-port expected-beat queues plus directed literal checks.
module tb_nf10_dst_port_demux;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NP = 8;
    localparam int SW = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  s_tdata;
    logic [SW-1:0]  s_tstrb;
    logic [UW-1:0]  s_tuser;
    logic           s_tvalid;
    logic           s_tready;
    logic           s_tlast;
    logic [DW-1:0]  m_tdata;
    logic [SW-1:0]  m_tstrb;
    logic [UW-1:0]  m_tuser;
    logic           m_tlast;
    logic [NP-1:0]  m_tvalid;
    logic [NP-1:0]  m_tready;
    logic [31:0]    drop_count;

    always #5 clk = ~clk;

    nf10_dst_port_demux dut (
        .AXI_ACLK      (clk),
        .AXI_RESET     (rst),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TSTRB  (s_tstrb),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .S_AXIS_TLAST  (s_tlast),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .DROP_COUNT    (drop_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t        exp_q [NP][$];
    logic [31:0]  model_drops;
    logic         in_pkt;
    logic [NP-1:0] pkt_dests;
    logic         sb_in_hs;
    int           total;
    int           bad;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference behaviour: every accepted beat of a packet goes to each port in its first-beat
    // bitmap; an empty first-beat bitmap discards the packet and counts one drop.
    task automatic sb_step();
        beat_t cur;
        beat_t in_b;
        sb_in_hs = 1'b0;
        if (rst) begin
            for (int i = 0; i < NP; i++) exp_q[i].delete();
            model_drops = '0;
            in_pkt      = 1'b0;
            return;
        end
        cur = '{data: m_tdata, strb: m_tstrb, user: m_tuser, last: m_tlast};
        for (int i = 0; i < NP; i++) begin
            if (m_tvalid[i]) begin
                total++;
                if (exp_q[i].size() == 0) begin
                    bad++;
                    $display("FAIL sb_port%0d_unexpected: got valid with data %0h want no beat", i, m_tdata[31:0]);
                end else if (exp_q[i][0] !== cur) begin
                    bad++;
                    $display("FAIL sb_port%0d_beat: got data %0h last %0b want data %0h last %0b",
                             i, m_tdata[31:0], m_tlast, exp_q[i][0].data[31:0], exp_q[i][0].last);
                end
                if (m_tready[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
            end
        end
        total++;
        if (drop_count !== model_drops) begin
            bad++;
            $display("FAIL sb_drop_count: got %0h want %0h", drop_count, model_drops);
        end
        if (s_tvalid && s_tready) begin
            sb_in_hs = 1'b1;
            in_b = '{data: s_tdata, strb: s_tstrb, user: s_tuser, last: s_tlast};
            if (!in_pkt) begin
                pkt_dests = s_tuser[24 +: NP];
                if (pkt_dests == '0) model_drops = model_drops + 32'd1;
            end
            for (int i = 0; i < NP; i++) if (pkt_dests[i]) exp_q[i].push_back(in_b);
            in_pkt = !s_tlast;
        end
    endtask

    task automatic clk_step();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [UW-1:0] mk_user(input logic [7:0] mask, input logic [31:0] tag);
        logic [UW-1:0] u;
        u = '0;
        u[95:64] = tag;
        u[31:24] = mask;
        return u;
    endfunction

    function automatic logic [DW-1:0] mk_data(input logic [31:0] tag);
        return {8{tag}};
    endfunction

    task automatic drive(input logic [7:0] mask, input logic [31:0] tag, input logic last);
        s_tdata  = mk_data(tag);
        s_tstrb  = tag ^ 32'h5A5A_5A5A;
        s_tuser  = mk_user(mask, tag);
        s_tlast  = last;
        s_tvalid = 1'b1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] mask, input int len, input logic [31:0] tag);
        for (int b = 0; b < len; b++) begin
            int n;
            drive((b == 0) ? mask : 8'($urandom), tag + 32'(b), b == len - 1);
            n = 0;
            do begin
                m_tready = 8'($urandom);
                clk_step();
                n++;
            end while (!sb_in_hs && n < 100);
            if (!sb_in_hs) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no accept after %0d cycles want accept", n);
            end
        end
        idle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_drops = '0;
        in_pkt = 1'b0;
        pkt_dests = '0;
        sb_in_hs = 1'b0;
        rst = 1'b1;
        s_tdata = '0;
        s_tstrb = '0;
        s_tuser = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 8'hFF;
        repeat (3) clk_step();
        rst = 1'b0;
        #1;
        chk("rst_tvalid", DW'(m_tvalid), 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tuser", DW'(m_tuser), 0);
        chk("rst_tlast", DW'(m_tlast), 0);
        chk("rst_drop", DW'(drop_count), 0);
        chk("rst_s_tready", DW'(s_tready), 1);

        // Unicast, 3 beats to port 2; later beats carry a zero bitmap that must be ignored.
        drive(8'h04, 32'hA000_0001, 1'b0);
        clk_step();
        chk("uni_v0", DW'(m_tvalid), 8'h04);
        chk("uni_d0", m_tdata, mk_data(32'hA000_0001));
        chk("uni_l0", DW'(m_tlast), 0);
        drive(8'h00, 32'hA000_0002, 1'b0);
        clk_step();
        chk("uni_v1", DW'(m_tvalid), 8'h04);
        chk("uni_d1", m_tdata, mk_data(32'hA000_0002));
        drive(8'h00, 32'hA000_0003, 1'b1);
        clk_step();
        chk("uni_v2", DW'(m_tvalid), 8'h04);
        chk("uni_l2", DW'(m_tlast), 1);
        idle();
        clk_step();
        chk("uni_idle", DW'(m_tvalid), 0);

        // Multicast to ports 0 and 2 with port 2 stalled.
        m_tready = 8'hFB;
        drive(8'h05, 32'hB000_0001, 1'b0);
        clk_step();
        chk("mc_v0", DW'(m_tvalid), 8'h05);
        chk("mc_u0", DW'(m_tuser), DW'(mk_user(8'h05, 32'hB000_0001)));
        drive(8'h00, 32'hB000_0002, 1'b1);
        #1;
        chk("mc_srdy0", DW'(s_tready), 0);
        for (int k = 0; k < 3; k++) begin
            clk_step();
            chk("mc_v_skew", DW'(m_tvalid), 8'h04);
            chk("mc_srdy_skew", DW'(s_tready), 0);
            chk("mc_hold", m_tdata, mk_data(32'hB000_0001));
        end
        m_tready = 8'hFF;
        #1;
        chk("mc_srdy_free", DW'(s_tready), 1);
        clk_step();
        chk("mc_v1", DW'(m_tvalid), 8'h05);
        chk("mc_d1", m_tdata, mk_data(32'hB000_0002));
        chk("mc_l1", DW'(m_tlast), 1);
        idle();
        clk_step();
        chk("mc_idle", DW'(m_tvalid), 0);

        // Empty-bitmap 4-beat drop, then a single beat to port 7.
        for (int b = 0; b < 4; b++) begin
            drive((b == 0) ? 8'h00 : 8'hFF, 32'hC000_0000 + 32'(b), b == 3);
            #1;
            chk("drop_srdy", DW'(s_tready), 1);
            clk_step();
            chk("drop_tvalid", DW'(m_tvalid), 0);
            chk("drop_count", DW'(drop_count), 1);
        end
        drive(8'h80, 32'hC000_0010, 1'b1);
        clk_step();
        chk("p7_v", DW'(m_tvalid), 8'h80);
        chk("p7_d", m_tdata, mk_data(32'hC000_0010));
        chk("p7_l", DW'(m_tlast), 1);
        idle();
        clk_step();

        // Back-to-back single-beat packets.
        for (int b = 1; b <= 3; b++) begin
            drive(8'(b), 32'hD000_0000 + 32'(b), 1'b1);
            clk_step();
            chk("b2b_v", DW'(m_tvalid), DW'(b));
        end
        idle();
        clk_step();
        chk("b2b_idle", DW'(m_tvalid), 0);

        // Reset in the middle of a packet.
        m_tready = 8'hEF;
        drive(8'h10, 32'hE000_0001, 1'b0);
        clk_step();
        chk("rmid_v0", DW'(m_tvalid), 8'h10);
        drive(8'h00, 32'hE000_0002, 1'b0);
        #1;
        chk("rmid_srdy", DW'(s_tready), 0);
        rst = 1'b1;
        clk_step();
        chk("rmid_tvalid", DW'(m_tvalid), 0);
        chk("rmid_drop", DW'(drop_count), 0);
        chk("rmid_srdy1", DW'(s_tready), 1);
        rst = 1'b0;
        idle();
        m_tready = 8'hFF;
        clk_step();
        drive(8'h10, 32'hE000_0003, 1'b1);
        clk_step();
        chk("rmid_new_v", DW'(m_tvalid), 8'h10);
        chk("rmid_new_d", m_tdata, mk_data(32'hE000_0003));
        idle();
        clk_step();

        // Drop counter wrap.
        force dut.drop_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.drop_count_reg;
        model_drops = 32'hFFFF_FFFF;
        chk("wrap_pre", DW'(drop_count), 32'hFFFF_FFFF);
        drive(8'h00, 32'hF000_0001, 1'b1);
        clk_step();
        chk("wrap_post", DW'(drop_count), 0);
        idle();
        clk_step();

        // Mixed traffic under random per-port backpressure.
        for (int p = 0; p < 16; p++) begin
            send_pkt((p % 5 == 4) ? 8'h00 : 8'($urandom_range(1, 255)), int'($urandom_range(1, 3)),
                     32'h1000_0000 + 32'(p * 16));
        end
        m_tready = 8'hFF;
        repeat (4) clk_step();
        for (int i = 0; i < NP; i++) chk("drain_empty", DW'(exp_q[i].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
